// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: merges load-use, branch-flush and
// multi-cycle data-memory hazards into per-stage controls, with memory timeout and perf counters.
module pipeline_stall_controller #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             load_use_i,
  input  logic             branch_taken_i,
  input  logic             mem_req_i,
  input  logic             mem_ack_i,
  output logic             pc_write_o,
  output logic             if_id_write_o,
  output logic             if_id_flush_o,
  output logic             id_ex_bubble_o,
  output logic             pipe_freeze_o,
  output logic             mem_enable_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RUN      = 2'd1,
    S_MEM_WAIT = 2'd2,
    S_HALT     = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              timeout_q, timeout_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic              active;
  logic              freeze;
  logic              bubble;
  logic              flush;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= S_IDLE;
      wait_q      <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    timeout_d = timeout_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_RUN;
      end
      S_RUN: begin
        if (mem_req_i && !mem_ack_i) begin
          state_d = S_MEM_WAIT;
          wait_d  = WAIT_W'(1);
        end
      end
      S_MEM_WAIT: begin
        // Ack wins over timeout when both land on the last allowed cycle.
        if (mem_ack_i) begin
          state_d = S_RUN;
          wait_d  = '0;
        end else if (wait_q == WAIT_LAST) begin
          state_d   = S_HALT;
          timeout_d = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    freeze = 1'b1;
    mem_enable_o = 1'b0;
    unique case (state_q)
      S_RUN: begin
        freeze       = mem_req_i && !mem_ack_i;
        mem_enable_o = mem_req_i;
      end
      S_MEM_WAIT: begin
        freeze       = !mem_ack_i;
        mem_enable_o = 1'b1;
      end
      default: begin
        freeze       = 1'b1;
        mem_enable_o = 1'b0;
      end
    endcase

    // Hazard arbitration applies only when the pipeline actually advances this edge.
    active = ((state_q == S_RUN) || (state_q == S_MEM_WAIT)) && !freeze;
    bubble = active && load_use_i;
    flush  = active && !load_use_i && branch_taken_i;

    pc_write_o     = active && !load_use_i;
    if_id_write_o  = active && !load_use_i;
    if_id_flush_o  = flush;
    id_ex_bubble_o = bubble;
    pipe_freeze_o  = freeze;
    timeout_o      = timeout_q;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if ((state_q == S_RUN) || (state_q == S_MEM_WAIT)) begin
      if ((freeze || bubble) && (stall_cnt_q != {CNT_W{1'b1}}))
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (flush && (flush_cnt_q != {CNT_W{1'b1}}))
        flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule
